conv_encoder_k3: RTL and testbench

CONV_ENCODER_K3 -- requirements
Module: conv_encoder_k3

---
 rtl/conv_pkg.sv | 30 +++
 rtl/conv_branch_sym.sv | 32 +++
 rtl/conv_encoder_k3.sv | 162 ++++++++++++++++
 tb/tb_conv_encoder_k3.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the K=3 convolutional code. The encoder and the
// Viterbi decoder's branch-metric logic both use these definitions.
//   K           : constraint length
//   G0_DEFAULT  : generator for the upper symbol bit, taps {b, s1, s0}
//   G1_DEFAULT  : generator for the lower symbol bit, taps {b, s1, s0}
//   conv_state_e: encoder frame FSM states
//   tap_parity  : XOR of the generator-selected taps
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int K = 3;
    localparam int TAIL_LEN = K - 1;

    localparam logic [K-1:0] G0_DEFAULT = 3'b111;
    localparam logic [K-1:0] G1_DEFAULT = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_TAIL = 2'b10
    } conv_state_e;

    // Parity of the taps selected by one generator polynomial.
    function automatic logic tap_parity(input logic [K-1:0] taps, input logic [K-1:0] gen);
        return ^(taps & gen);
    endfunction

endpackage

// File: rtl/conv_branch_sym.sv
// -----------------------------------------------------------------------------
// conv_branch_sym
// Combinational branch-symbol generator: the 2-bit code symbol produced when
// bit b enters an encoder holding state {s1, s0}. The decoder also uses it for
// its expected-symbol generation.
//   b    : information (or flush) bit being encoded
//   s1   : previous input bit
//   s0   : input bit before s1
//   g0   : generator for sym[1], taps {b, s1, s0}
//   g1   : generator for sym[0], taps {b, s1, s0}
//   sym  : {g0 parity, g1 parity}
// -----------------------------------------------------------------------------
module conv_branch_sym
    import conv_pkg::*;
(
    input  logic         b,
    input  logic         s1,
    input  logic         s0,
    input  logic [K-1:0] g0,
    input  logic [K-1:0] g1,
    output logic [1:0]   sym
);

    logic [K-1:0] taps_s;

    // Form the tap vector and reduce it under each generator.
    always_comb begin
        taps_s = {b, s1, s0};
        sym    = {tap_parity(taps_s, g0), tap_parity(taps_s, g1)};
    end

endmodule

// File: rtl/conv_encoder_k3.sv
// -----------------------------------------------------------------------------
// conv_encoder_k3
// Rate-1/2, K=3 convolutional encoder with valid/ready streaming on both sides
// and an optional two-bit zero tail that terminates each frame in state 00.
// The output is a single register stage. It sustains one symbol per cycle
// because a symbol can retire and a new one can load in the same cycle.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_bit / in_last valid
//   in_ready  : encoder accepts an input bit this cycle
//   in_bit    : information bit
//   in_last   : final information bit of the frame
//   out_valid : out_sym / out_last valid
//   out_ready : downstream accepts the symbol
//   out_sym   : coded symbol {G0 bit, G1 bit}
//   out_last  : final symbol of the frame, tail included
//   busy      : frame in progress (RUN or TAIL)
// -----------------------------------------------------------------------------
module conv_encoder_k3
    import conv_pkg::*;
#(
    parameter logic [K-1:0] G0      = G0_DEFAULT,
    parameter logic [K-1:0] G1      = G1_DEFAULT,
    parameter bit           TAIL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_sym,
    output logic       out_last,
    output logic       busy
);

    conv_state_e state_r, state_n_s;
    logic [1:0]  enc_st_r, enc_st_n_s;     // {s1, s0}
    logic        tail_cnt_r, tail_cnt_n_s; // 0: first flush bit next, 1: second
    logic        out_valid_r, out_valid_n_s;
    logic [1:0]  out_sym_r, out_sym_n_s;
    logic        out_last_r, out_last_n_s;
    logic        busy_r;

    logic        out_free_s;
    logic        in_ready_s;
    logic        accept_s;
    logic        tail_issue_s;
    logic        enc_bit_s;
    logic [1:0]  sym_s;

    // The output register can take a new symbol if empty or retiring now.
    // in_ready is forced low while reset is asserted.
    assign out_free_s   = !out_valid_r || out_ready;
    assign in_ready_s   = rst_n && (state_r != ST_TAIL) && out_free_s;
    assign accept_s     = in_valid && in_ready_s;
    assign tail_issue_s = (state_r == ST_TAIL) && out_free_s;
    assign enc_bit_s    = (state_r == ST_TAIL) ? 1'b0 : in_bit;

    conv_branch_sym u_branch (
        .b   (enc_bit_s),
        .s1  (enc_st_r[1]),
        .s0  (enc_st_r[0]),
        .g0  (G0),
        .g1  (G1),
        .sym (sym_s)
    );

    // Next-state logic for the frame FSM, encoder shift state and output stage.
    always_comb begin
        state_n_s     = state_r;
        enc_st_n_s    = enc_st_r;
        tail_cnt_n_s  = tail_cnt_r;
        out_valid_n_s = out_valid_r;
        out_sym_n_s   = out_sym_r;
        out_last_n_s  = out_last_r;

        if (accept_s) begin
            out_valid_n_s = 1'b1;
            out_sym_n_s   = sym_s;
            enc_st_n_s    = {in_bit, enc_st_r[1]};
            tail_cnt_n_s  = 1'b0;
            if (in_last) begin
                if (TAIL_EN) begin
                    state_n_s    = ST_TAIL;
                    out_last_n_s = 1'b0;
                end else begin
                    // Without a tail the next frame still has to start from 00.
                    state_n_s    = ST_IDLE;
                    enc_st_n_s   = 2'b00;
                    out_last_n_s = 1'b1;
                end
            end else begin
                state_n_s    = ST_RUN;
                out_last_n_s = 1'b0;
            end
        end else if (tail_issue_s) begin
            out_valid_n_s = 1'b1;
            out_sym_n_s   = sym_s;
            if (tail_cnt_r) begin
                out_last_n_s = 1'b1;
                state_n_s    = ST_IDLE;
                enc_st_n_s   = 2'b00;
                tail_cnt_n_s = 1'b0;
            end else begin
                out_last_n_s = 1'b0;
                enc_st_n_s   = {1'b0, enc_st_r[1]};
                tail_cnt_n_s = 1'b1;
            end
        end else if (out_valid_r && out_ready) begin
            out_valid_n_s = 1'b0;
            out_last_n_s  = 1'b0;
        end else begin
            // Stalled or idle: everything holds.
            out_valid_n_s = out_valid_r;
        end

        // An unreachable state encoding recovers to a clean idle.
        case (state_r)
            ST_IDLE, ST_RUN, ST_TAIL: begin
                state_n_s = state_n_s;
            end
            default: begin
                state_n_s     = ST_IDLE;
                enc_st_n_s    = 2'b00;
                tail_cnt_n_s  = 1'b0;
                out_valid_n_s = 1'b0;
                out_last_n_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            enc_st_r    <= 2'b00;
            tail_cnt_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_sym_r   <= 2'b00;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            enc_st_r    <= enc_st_n_s;
            tail_cnt_r  <= tail_cnt_n_s;
            out_valid_r <= out_valid_n_s;
            out_sym_r   <= out_sym_n_s;
            out_last_r  <= out_last_n_s;
            busy_r      <= (state_n_s != ST_IDLE);
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_sym   = out_sym_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_conv_encoder_k3.sv
// -----------------------------------------------------------------------------
// tb_conv_encoder_k3
// Self-checking bench for conv_encoder_k3: a per-cycle vector table for the
// basic frames and back-pressure, then hand-written sequences for reset during
// the tail, the no-tail variant and a long streaming frame against a model.
// -----------------------------------------------------------------------------
module tb_conv_encoder_k3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_bit, in_last, out_ready;
    logic       in_ready, out_valid, out_last, busy;
    logic [1:0] out_sym;

    logic       z_in_valid, z_in_bit, z_in_last, z_out_ready;
    logic       z_in_ready, z_out_valid, z_out_last, z_busy;
    logic [1:0] z_out_sym;

    int checks   = 0;
    int failures = 0;

    logic [1:0] got_sym[$];
    logic       got_last[$];
    int         got_cyc[$];
    logic [1:0] exp_sym[$];
    logic       exp_last[$];

    typedef struct {
        logic       iv, ib, il, ordy;
        logic       ev;
        logic [1:0] es;
        logic       el, eb, eir;
    } vec_t;

    vec_t tbl[22];

    always #5 clk = ~clk;

    conv_encoder_k3 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sym(out_sym), .out_last(out_last), .busy(busy)
    );

    conv_encoder_k3 #(.TAIL_EN(1'b0)) dut_notail (
        .clk(clk), .rst_n(rst_n), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .in_bit(z_in_bit), .in_last(z_in_last), .out_valid(z_out_valid),
        .out_ready(z_out_ready), .out_sym(z_out_sym), .out_last(z_out_last), .busy(z_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference encoder for G0=111, G1=101: sym = {b^s1^s0, b^s0}.
    task automatic ref_encode(input logic [63:0] bits, input int n, input bit tail);
        logic s1, s0, b;
        exp_sym.delete();
        exp_last.delete();
        s1 = 1'b0;
        s0 = 1'b0;
        for (int i = 0; i < n + (tail ? 2 : 0); i++) begin
            b = (i < n) ? bits[i] : 1'b0;
            exp_sym.push_back({b ^ s1 ^ s0, b ^ s0});
            exp_last.push_back(tail ? (i == n + 1) : (i == n - 1));
            s0 = s1;
            s1 = b;
        end
    endtask

    // Stream one frame into dut with out_ready=1 for a fixed cycle budget,
    // capturing every valid symbol and the cycle it appeared in.
    task automatic send_frame(input logic [63:0] bits, input int n, input int max_cycles);
        int idx = 0;
        got_sym.delete();
        got_last.delete();
        got_cyc.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            if (out_valid) begin
                got_sym.push_back(out_sym);
                got_last.push_back(out_last);
                got_cyc.push_back(cyc);
            end
            if (idx < n) begin
                in_valid = 1'b1;
                in_bit   = bits[idx];
                in_last  = (idx == n - 1);
            end else begin
                in_valid = 1'b0;
                in_bit   = 1'b0;
                in_last  = 1'b0;
            end
            #1;
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic compare_frame(input string name);
        int n;
        chk({name, "_count"}, got_sym.size(), exp_sym.size());
        n = (got_sym.size() < exp_sym.size()) ? got_sym.size() : exp_sym.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_sym%0d", name, i), got_sym[i], exp_sym[i]);
            chk($sformatf("%s_last%0d", name, i), got_last[i], exp_last[i]);
        end
        if (got_sym.size() > 0) begin
            chk({name, "_consecutive"}, got_cyc[got_cyc.size()-1] - got_cyc[0] + 1, got_sym.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // iv ib il ordy | ev es el busy in_ready
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        in_last     = 1'b0;
        out_ready   = 1'b1;
        z_in_valid  = 1'b0;
        z_in_bit    = 1'b0;
        z_in_last   = 1'b0;
        z_out_ready = 1'b1;

        // Reset state.
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sym", out_sym, 2'b00);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table: 1,0,1,1 frame; single bit 0 frame; back-pressure.
        for (int i = 0; i < 22; i++) begin
            in_valid  = tbl[i].iv;
            in_bit    = tbl[i].ib;
            in_last   = tbl[i].il;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_out_sym", i), out_sym, tbl[i].es);
                chk($sformatf("vec%0d_out_last", i), out_last, tbl[i].el);
            end
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].eir);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset asserted during the tail of a 1,1 frame.
        in_valid = 1'b1;
        in_bit   = 1'b1;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        in_last = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("midrst_pre_busy", busy, 1'b1);
        chk("midrst_pre_valid", out_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(64'h1, 1, 8);
        exp_sym  = '{2'b11, 2'b10, 2'b11};
        exp_last = '{1'b0, 1'b0, 1'b1};
        compare_frame("after_rst");
        chk("after_rst_busy", busy, 1'b0);

        // TAIL_EN=0: bits 1,1 with last -> 11, 01; then state must be 00.
        z_in_valid = 1'b1;
        z_in_bit   = 1'b1;
        z_in_last  = 1'b0;
        #1;
        chk("notail_c0_valid", z_out_valid, 1'b0);
        chk("notail_c0_in_ready", z_in_ready, 1'b1);
        @(posedge clk);
        #1;
        z_in_last = 1'b1;
        #1;
        chk("notail_c1_valid", z_out_valid, 1'b1);
        chk("notail_c1_sym", z_out_sym, 2'b11);
        chk("notail_c1_last", z_out_last, 1'b0);
        @(posedge clk);
        #1;
        z_in_valid = 1'b0;
        z_in_last  = 1'b0;
        #1;
        chk("notail_c2_valid", z_out_valid, 1'b1);
        chk("notail_c2_sym", z_out_sym, 2'b01);
        chk("notail_c2_last", z_out_last, 1'b1);
        chk("notail_c2_busy", z_busy, 1'b0);
        @(posedge clk);
        #1;
        chk("notail_c3_valid", z_out_valid, 1'b0);
        z_in_valid = 1'b1;
        z_in_bit   = 1'b1;
        z_in_last  = 1'b1;
        @(posedge clk);
        #1;
        z_in_valid = 1'b0;
        z_in_last  = 1'b0;
        chk("notail_next_sym", z_out_sym, 2'b11);
        chk("notail_next_last", z_out_last, 1'b1);
        @(posedge clk);
        #1;
        chk("notail_next_drained", z_out_valid, 1'b0);

        // 64-bit frame streamed back to back against the reference model.
        ref_encode(64'hA5C3_0F96_1E7B_D248, 64, 1'b1);
        send_frame(64'hA5C3_0F96_1E7B_D248, 64, 72);
        compare_frame("long");
        chk("long_busy_after", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
